logic_sweep_unit: RTL and testbench
===================================

LOGIC_SWEEP_UNIT -- requirements
Module: logic_sweep_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port op  input  3  function select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 INHIBIT (~a & b), 111 IMPLY (~a | b).
REQ-005 SHALL have port a  input  WIDTH  operand a.
REQ-006 SHALL have port b  input  WIDTH  operand b.
REQ-007 SHALL have port in_valid  input  1  operand pair offered.
REQ-008 SHALL have port in_ready  output  1  operand pair accepted this cycle when in_valid is also high.
REQ-009 SHALL have port sweep_start  input  1  request a truth-table sweep using the current op.
REQ-010 SHALL have port y  output  WIDTH  registered result.
REQ-011 SHALL have port out_valid  output  1  y holds an unconsumed result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts y this cycle.
REQ-013 SHALL have port out_sweep  output  1  result came from a sweep.
REQ-014 SHALL have port out_idx  output  2  sweep step of result: {a_bit, b_bit}; 00 for normal results.
REQ-015 SHALL have port busy  output  1  state is not IDLE.
REQ-016 SHALL have port sweep_done  output  1  one-cycle pulse at sweep completion.

Function
REQ-017 SHALL compute each result bitwise per op over WIDTH bits, with no carries or cross-bit interaction.
REQ-018 SHALL use one output register; load condition "adv" = !out_valid || out_ready.
REQ-019 SHALL drive in_ready = (state==IDLE) && !sweep_start && adv, combinationally.
REQ-020 SHALL, on in_valid && in_ready, load y, set out_valid=1, out_sweep=0, out_idx=00; latency is 1 cycle.
REQ-021 SHALL clear out_valid on out_valid && out_ready when no new load occurs in the same cycle; a simultaneous accept and load keeps out_valid=1 with the new data.
REQ-022 SHALL hold y, out_sweep and out_idx stable while out_valid && !out_ready.
REQ-023 SHALL implement states IDLE, SWEEP, DRAIN.
REQ-024 SHALL, in IDLE with sweep_start=1, latch op into sweep_op, clear step counter to 0 and enter SWEEP; sweep_start wins over a simultaneous in_valid, which is not accepted.
REQ-025 SHALL ignore sweep_start outside IDLE.
REQ-026 SHALL, in SWEEP and when adv, load y = sweep_op applied to a = {WIDTH{step[1]}}, b = {WIDTH{step[0]}}, with out_sweep=1, out_idx=step, then increment step.
REQ-027 SHALL keep step frozen in SWEEP when adv=0 (back-pressure stalls the sweep, no result lost).
REQ-028 SHALL move SWEEP->DRAIN in the cycle step 3 is loaded.
REQ-029 SHALL, in DRAIN, wait for out_valid && out_ready with out_idx==3, then return to IDLE and assert sweep_done in the next cycle for exactly one cycle.
REQ-030 SHALL keep in_ready=0 throughout SWEEP and DRAIN; op changes during a sweep have no effect.

Reset
REQ-031 SHALL, on rst_n=0, immediately set state=IDLE, step=0, y=0, out_valid=0, out_sweep=0, out_idx=00, sweep_done=0, busy=0, regardless of clk.
REQ-032 SHALL discard any in-flight result or partial sweep on reset; no sweep_done is generated for an aborted sweep.
REQ-033 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification (WIDTH=4)
REQ-034 SHALL cover normal op: op=110, a=0011, b=0101, in_valid=1, out_ready=1 -> next cycle y=0100, out_valid=1, out_sweep=0.
REQ-035 SHALL cover all eight ops with a=0011, b=0101 -> y = 0001, 0111, 0110, 1110, 1000, 1001, 0100, 1101.
REQ-036 SHALL cover sweep: op=100, sweep_start pulse, out_ready=1 -> y=1111, 0000, 0000, 0000 with out_idx 00..11 on consecutive cycles, busy high, sweep_done one pulse after idx 11 is accepted.
REQ-037 SHALL cover back-pressure: op=110 sweep, out_ready=0 for 3 cycles at idx 01 -> y=1111 held stable, step frozen; sequence 0000, 1111, 0000, 0000 completes intact.
REQ-038 SHALL cover collision: sweep_start and in_valid together in IDLE -> in_ready=0, sweep runs, operand pair accepted only after return to IDLE.
REQ-039 SHALL cover reset mid-sweep: rst_n low at idx 10 -> all outputs 0 asynchronously, no sweep_done, next in_valid accepted normally.

Source files
------------

// File: rtl/logic_sweep_unit.sv
// logic_sweep_unit: registered bitwise logic unit with a valid/ready result
// port and a four-step truth-table sweep mode.
//
// Normal operation applies the selected function to (a, b) and delivers the
// result one cycle later. A sweep replays the latched function over the four
// operand combinations {a_bit, b_bit} = 00, 01, 10, 11. Each combination is
// replicated across all WIDTH bits. Results leave in order through the same
// output register, which honours back-pressure.
module logic_sweep_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sweep_start,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sweep,
    output logic [1:0]       out_idx,
    output logic             busy,
    output logic             sweep_done
);

    // Function select encoding; every 3-bit value is a legal function.
    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NAND  = 3'b011,
        OP_NOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_INHIB = 3'b110,
        OP_IMPLY = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Purely bitwise: each result bit depends only on the same bit of a and b.
    function automatic logic [WIDTH-1:0] apply_op(
        input op_t              f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] r;
        case (f)
            OP_AND:   r = x & z;
            OP_OR:    r = x | z;
            OP_XOR:   r = x ^ z;
            OP_NAND:  r = ~(x & z);
            OP_NOR:   r = ~(x | z);
            OP_XNOR:  r = ~(x ^ z);
            OP_INHIB: r = ~x & z;
            OP_IMPLY: r = ~x | z;
            default:  r = '0;
        endcase
        return r;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [1:0]       step;
    logic [1:0]       step_next;
    op_t              sweep_op;
    op_t              sweep_op_next;
    logic             done_next;

    logic             adv;
    logic             load_norm;
    logic             load_sweep;
    logic [WIDTH-1:0] sweep_a;
    logic [WIDTH-1:0] sweep_b;
    logic [WIDTH-1:0] result;

    // The output register can take new data when it is empty or being drained.
    assign adv       = !out_valid || out_ready;
    // A sweep request takes priority over an operand pair offered in the same cycle.
    assign in_ready  = (state == IDLE) && !sweep_start && adv;
    assign load_norm = in_valid && in_ready;
    assign busy      = (state != IDLE);

    // Sweep operands: step[1] drives every bit of a, step[0] every bit of b.
    assign sweep_a = {WIDTH{step[1]}};
    assign sweep_b = {WIDTH{step[0]}};

    // Select the operand source for whichever load happens this cycle.
    always_comb begin
        result = '0;
        if (load_norm) begin
            result = apply_op(op_t'(op), a, b);
        end else begin
            result = apply_op(sweep_op, sweep_a, sweep_b);
        end
    end

    // Next-state logic for the sweep sequencer and its control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        state_next    = state;
        step_next     = step;
        sweep_op_next = sweep_op;
        load_sweep    = 1'b0;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    sweep_op_next = op_t'(op);
                    step_next     = 2'd0;
                    state_next    = SWEEP;
                end
            end
            SWEEP: begin
                // Back-pressure freezes the step so no sweep result is lost.
                if (adv) begin
                    load_sweep = 1'b1;
                    step_next  = step + 2'd1;
                    if (step == 2'd3) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The sweep finishes only when the consumer takes the last step.
                if (out_valid && out_ready && (out_idx == 2'd3)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer state, step counter, latched sweep function and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= 2'd0;
            sweep_op   <= OP_AND;
            sweep_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before the clock edge.
            state      <= state_next;
            step       <= step_next;
            sweep_op   <= sweep_op_next;
            sweep_done <= done_next;
        end
    end

    // Output register: load normal or sweep results, clear valid on consumption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y         <= '0;
            out_valid <= 1'b0;
            out_sweep <= 1'b0;
            out_idx   <= 2'd0;
        end else if (load_norm) begin
            y         <= result;
            out_valid <= 1'b1;
            out_sweep <= 1'b0;
            out_idx   <= 2'd0;
        end else if (load_sweep) begin
            y         <= result;
            out_valid <= 1'b1;
            out_sweep <= 1'b1;
            out_idx   <= step;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// tb_logic_sweep_unit: directed vectors for logic_sweep_unit (WIDTH=4).
// The stimulus pushes expected results into a scoreboard queue. A monitor
// pops and compares each result as the DUT hands it over.
module tb_logic_sweep_unit;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sweep_start = 1'b0;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_sweep;
    logic [1:0]       out_idx;
    logic             busy;
    logic             sweep_done;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             sw;
        logic [1:0]       idx;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    bit   done_pending = 1'b0;

    // Hand-computed results for ops 000..111 with a=0011, b=0101.
    logic [WIDTH-1:0] op_exp [8] = '{4'b0001, 4'b0111, 4'b0110, 4'b1110,
                                     4'b1000, 4'b1001, 4'b0100, 4'b1101};

    logic_sweep_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sweep_start (sweep_start),
        .y           (y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sweep   (out_sweep),
        .out_idx     (out_idx),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] yv, input logic sw, input logic [1:0] idx);
        exp_t e;
        e.y   = yv;
        e.sw  = sw;
        e.idx = idx;
        sb.push_back(e);
    endtask

    // Wait (bounded) until all expected results are consumed and the unit is idle.
    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 50) begin
            tick();
            n++;
        end
        check_eq(name, 32'(sb.size() == 0 && !busy), 1);
        tick();
        tick();
    endtask

    // Monitor: compare each handed-over result and track the sweep_done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check_eq("sweep_done", 32'(sweep_done), 32'(done_pending));
                done_pending = 1'b0;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_output_sb_depth", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check_eq("y", 32'(y), 32'(e.y));
                        check_eq("out_sweep", 32'(out_sweep), 32'(e.sw));
                        check_eq("out_idx", 32'(out_idx), 32'(e.idx));
                        if (e.sw && e.idx == 2'd3) begin
                            done_pending = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected results pending", sb.size());
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        bit accepted;

        // Reset state
        #2;
        check_eq("rst_y", 32'(y), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_sweep", 32'(out_sweep), 0);
        check_eq("rst_out_idx", 32'(out_idx), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_sweep_done", 32'(sweep_done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // All eight ops, streaming back-to-back with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op       = i[2:0];
            a        = 4'b0011;
            b        = 4'b0101;
            in_valid = 1'b1;
            #1;
            check_eq("in_ready_stream", 32'(in_ready), 1);
            push(op_exp[i], 1'b0, 2'd0);
            tick();
        end
        in_valid = 1'b0;
        wait_drain("stream_drain");

        // Back-pressure on the normal path, then simultaneous accept and load
        op        = 3'b001;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        check_eq("in_ready_empty", 32'(in_ready), 1);
        push(4'b0111, 1'b0, 2'd0);
        tick();
        op = 3'b010;
        #1;
        check_eq("in_ready_full", 32'(in_ready), 0);
        check_eq("out_valid_full", 32'(out_valid), 1);
        tick();
        check_eq("y_hold_normal", 32'(y), 32'(4'b0111));
        check_eq("in_ready_still_full", 32'(in_ready), 0);
        out_ready = 1'b1;
        #1;
        check_eq("in_ready_accept_load", 32'(in_ready), 1);
        push(4'b0110, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        wait_drain("accept_load_drain");

        // NOR sweep with the consumer always ready
        op          = 3'b100;
        sweep_start = 1'b1;
        #1;
        check_eq("in_ready_sweep_start", 32'(in_ready), 0);
        push(4'b1111, 1'b1, 2'd0);
        push(4'b0000, 1'b1, 2'd1);
        push(4'b0000, 1'b1, 2'd2);
        push(4'b0000, 1'b1, 2'd3);
        tick();
        sweep_start = 1'b0;
        check_eq("busy_nor_sweep", 32'(busy), 1);
        wait_drain("nor_sweep_done");

        // INHIBIT sweep with a 3-cycle stall while idx 01 is presented
        op          = 3'b110;
        sweep_start = 1'b1;
        push(4'b0000, 1'b1, 2'd0);
        push(4'b1111, 1'b1, 2'd1);
        push(4'b0000, 1'b1, 2'd2);
        push(4'b0000, 1'b1, 2'd3);
        tick();
        sweep_start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("stall_idx_enter", 32'(out_idx), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("stall_y_hold", 32'(y), 32'(4'b1111));
            check_eq("stall_idx_hold", 32'(out_idx), 1);
            check_eq("stall_valid_hold", 32'(out_valid), 1);
            check_eq("stall_busy", 32'(busy), 1);
        end
        out_ready = 1'b1;
        wait_drain("stall_sweep_done");

        // Collision: sweep_start and in_valid together; op changes mid-sweep
        op          = 3'b000;
        a           = 4'b0011;
        b           = 4'b0101;
        in_valid    = 1'b1;
        sweep_start = 1'b1;
        #1;
        check_eq("collision_in_ready", 32'(in_ready), 0);
        push(4'b0000, 1'b1, 2'd0);
        push(4'b0000, 1'b1, 2'd1);
        push(4'b0000, 1'b1, 2'd2);
        push(4'b1111, 1'b1, 2'd3);
        tick();
        sweep_start = 1'b0;
        op          = 3'b111;
        accepted    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!accepted) begin
                if (busy) begin
                    check_eq("in_ready_while_busy", 32'(in_ready), 0);
                end
                if (in_ready) begin
                    push(4'b1101, 1'b0, 2'd0);
                    accepted = 1'b1;
                end
                tick();
            end
        end
        in_valid = 1'b0;
        check_eq("collision_pair_accepted", 32'(accepted), 1);
        wait_drain("collision_drain");

        // Reset in the middle of a XOR sweep while idx 10 is presented
        op          = 3'b010;
        sweep_start = 1'b1;
        push(4'b0000, 1'b1, 2'd0);
        push(4'b1111, 1'b1, 2'd1);
        tick();
        sweep_start = 1'b0;
        tick();
        tick();
        tick();
        check_eq("pre_reset_idx", 32'(out_idx), 2);
        check_eq("pre_reset_y", 32'(y), 32'(4'b1111));
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_y", 32'(y), 0);
        check_eq("async_rst_out_valid", 32'(out_valid), 0);
        check_eq("async_rst_out_sweep", 32'(out_sweep), 0);
        check_eq("async_rst_out_idx", 32'(out_idx), 0);
        check_eq("async_rst_busy", 32'(busy), 0);
        check_eq("async_rst_sweep_done", 32'(sweep_done), 0);
        check_eq("pre_reset_pending", sb.size(), 0);
        sb.delete();
        done_pending = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        op       = 3'b000;
        in_valid = 1'b1;
        #1;
        check_eq("post_reset_in_ready", 32'(in_ready), 1);
        push(4'b0001, 1'b0, 2'd0);
        tick();
        in_valid = 1'b0;
        wait_drain("post_reset_drain");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
